// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
`default_nettype none

package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    MULT  = 3'b000,
    MULTU = 3'b001,
    DIV   = 3'b010,
    DIVU  = 3'b011,
    MTHI  = 3'b100,
    MTLO  = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_hilo.sv
// ============================================================================
// muldiv_hilo : iterative radix-2 multiply/divide unit with HI/LO registers
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module muldiv_hilo
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rsel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  state_t      r_state;
  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic [31:0] r_araw;
  logic [5:0]  r_cnt;
  logic        r_isdiv;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_amag;
  logic [31:0] w_bmag;
  logic [32:0] w_sum;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_signed = (op == MULT) || (op == DIV);
  assign w_sa     = w_signed & a[31];
  assign w_sb     = w_signed & b[31];
  assign w_amag   = w_sa ? -a : a;
  assign w_bmag   = w_sb ? -b : b;

  // Multiply: accumulator high half gathers partial sums, low half holds the
  // multiplier and is shifted out one bit per step.
  assign w_sum = {1'b0, r_acc[63:32]} + {1'b0, r_opb};

  // Restoring divide: the 33-bit shifted remainder can exceed 32 bits, so the
  // compare uses r_acc[63:31]; when it succeeds the true difference fits in 32.
  assign w_ge  = r_acc[63:31] >= {1'b0, r_opb};
  assign w_sub = r_acc[62:31] - r_opb;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_opb   <= '0;
      r_araw  <= '0;
      r_cnt   <= '0;
      r_isdiv <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            case (op)
              MULT, MULTU, DIV, DIVU: begin
                r_isdiv <= op[1];
                r_acc   <= op[1] ? {32'd0, w_amag} : {32'd0, w_bmag};
                r_opb   <= op[1] ? w_bmag : w_amag;
                r_araw  <= a;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_dz    <= op[1] && (b == 32'd0);
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= RUN;
              end
              MTHI:    r_hi <= a;
              MTLO:    r_lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (r_isdiv)
            r_acc <= w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
          else
            r_acc <= r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(ITER - 1))
            r_state <= FIX;
        end
        FIX: begin
          if (!r_isdiv) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (r_dz) begin
            r_hi <= r_araw;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign rdata = rsel ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: vector table plus directed corner sequences.
`default_nettype none

module tb_muldiv_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rsel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_hilo dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rsel  (rsel),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Launch a multi-cycle op, optionally hammering start during busy, and check
  // latency, hold-while-busy, done pulse and the final HI/LO/rdata.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                        input bit inject);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 5) begin
        chk({name, " hold_hi"}, hi, m_hi);
        chk({name, " hold_lo"}, lo, m_lo);
        chk({name, " no_early_done"}, {31'd0, done}, 32'd0);
      end
      if (inject) begin
        case (cyc)
          3:  begin start = 1'b1; op = 3'b100; a = 32'hDEADBEEF; end
          4:  start = 1'b0;
          10: begin start = 1'b1; op = 3'b001; a = 32'd1; b = 32'd1; end
          11: start = 1'b0;
          33: begin start = 1'b1; op = 3'b101; a = 32'd77; end
          default: ;
        endcase
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " busy_cycles"}, 32'(cyc), 32'd33);
    chk({name, " done"}, {31'd0, done}, 32'd1);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    rsel = 1'b1; #1;
    chk({name, " rdata_hi"}, rdata, eh);
    rsel = 1'b0; #1;
    chk({name, " rdata_lo"}, rdata, el);
    m_hi = eh; m_lo = el;
    @(negedge clk);
    chk({name, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, " idle_lo"}, lo, el);
  endtask

  initial begin
    int cyc;
    int seen;
    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{3'b011, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{3'b010, 32'h00000064, 32'h0000000A, 32'h00000000, 32'h0000000A};
    vecs[11] = '{3'b010, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[13] = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[14] = '{3'b000, 32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4};

    reset = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; rsel = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);

    // start while reset is asserted must be ignored
    start = 1'b1; op = 3'b101; a = 32'h9;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_reset lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // MTLO / MTHI from idle
    start = 1'b1; op = 3'b101; a = 32'd5;
    @(negedge clk);
    start = 1'b0; rsel = 1'b0; #1;
    chk("mtlo lo", lo, 32'd5);
    chk("mtlo rdata", rdata, 32'd5);
    chk("mtlo done", {31'd0, done}, 32'd0);
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; rsel = 1'b1; #1;
    chk("mthi rdata", rdata, 32'hCAFEF00D);
    m_hi = 32'hCAFEF00D; m_lo = 32'd5;

    // reserved opcodes leave everything alone
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(k); a = 32'h1111; b = 32'h2222;
      @(negedge clk);
      start = 1'b0;
      chk("noop hi", hi, m_hi);
      chk("noop lo", lo, m_lo);
      chk("noop busy", {31'd0, busy}, 32'd0);
    end

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);

    // starts during busy (including the FIX cycle) are ignored
    run_op("busywin", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    @(negedge clk);
    chk("busywin after hi", hi, 32'd0);
    chk("busywin after lo", lo, 32'd42);
    chk("busywin after busy", {31'd0, busy}, 32'd0);

    // abort a DIVU on iteration edge 10
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    seen = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort no_done", 32'(seen), 32'd0);
    m_hi = '0; m_lo = '0;
    run_op("post_abort", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter: none; iteration count fixed at 32 via package constant.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 start  input  1  command strobe; sampled on each rising edge.
REQ-005 op  input  3  command: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 a  input  32  operand A: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 b  input  32  operand B: multiplier or divisor.
REQ-008 busy  output  1  multiply/divide in progress.
REQ-009 done  output  1  one-cycle pulse: HI/LO just updated by MULT/MULTU/DIV/DIVU.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.
REQ-012 rsel  input  1  read select for mfhi/mflo: 1 = HI, 0 = LO.
REQ-013 rdata  output  32  combinational, rsel ? hi : lo.

Function
REQ-014 Command accepted on a rising edge where reset=1, start=1 and busy=0; start with busy=1 is ignored, with no effect on state.
REQ-015 MTHI/MTLO: on the accepting edge, load a into HI/LO; busy stays 0; done stays 0.
REQ-016 Opcodes 110/111: no state change.
REQ-017 FSM states IDLE, RUN, FIX.
- IDLE to RUN on accepted MULT/MULTU/DIV/DIVU.
- RUN to FIX after 32 iteration edges.
- FIX to IDLE on the next edge.
REQ-018 Accepting edge E0 latches operand magnitudes, result signs and the divide-by-zero flag.
- Signed ops take two's-complement magnitudes.
- Unsigned ops use the raw operands.
REQ-019 Iteration edges E1..E32 perform one radix-2 step each: shift-add for multiply, restoring subtract for divide.
REQ-020 On edge E33 (FIX):
- apply sign correction and write HI/LO;
- busy becomes 0;
- done is 1 for exactly the cycle after E33.
REQ-021 busy=1 from the cycle after E0 through the cycle ending at E33.
REQ-022 Multiply result is the full 64-bit product: HI = bits 63:32, LO = bits 31:0.
- MULT: signed x signed.
- MULTU: unsigned x unsigned.
REQ-023 Divide: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
REQ-024 Divide by zero (b=0, DIV or DIVU): HI = a, LO = 32'hFFFFFFFF, same latency and done pulse.
REQ-025 Signed overflow (DIV, a=32'h80000000, b=32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
REQ-026 HI/LO are unchanged while busy=1; rdata returns the old values until E33.
REQ-027 Operands a and b need only be valid on the accepting edge.

Reset
REQ-028 On an edge with reset=0, regardless of state (including mid-RUN):
- FSM to IDLE;
- hi=0, lo=0, busy=0, done=0;
- all internal datapath registers cleared;
- any in-flight operation is abandoned with no partial HI/LO write.
REQ-029 start is ignored on any edge where reset=0.

Structure
REQ-030 Shared package muldiv_pkg holds:
- the op enum (MULT, MULTU, DIV, DIVU, MTHI, MTLO);
- the FSM state enum (IDLE, RUN, FIX);
- constant ITER=32.
REQ-031 Single module; no sub-module. The 64-bit accumulator/remainder and the 6-bit iteration counter are local registers.

Verification
REQ-032 MULT a=32'hFFFFFFFD, b=32'h00000007 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; done in the cycle after E33; busy high for exactly 33 cycles.
REQ-033 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; MULT with the same operands -> hi=0, lo=1.
REQ-034 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-035 DIVU a=32'h00001234, b=0 -> hi=32'h00001234, lo=32'hFFFFFFFF; DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-036 Busy-window behaviour:
- start (MULT, then MTHI a=32'hDEADBEEF) asserted during busy -> ignored; HI/LO hold the first op's result.
- MTLO a=5 when idle -> lo=5 next cycle; rdata with rsel=0 equals 5; done stays 0.
REQ-037 reset=0 on iteration edge 10 of a DIVU -> next cycle busy=0, done=0, hi=lo=0; done never pulses for the aborted op; a following MULTU 3x4 gives lo=12, hi=0.
